// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default constants and clog2 helper shared by the UART RX/TX blocks
package uart_pkg;
    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS_DEF = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte interface between the UART receiver and the core
interface uart_rx_if #(parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF);
    logic [DATA_BITS-1:0] data_out;
    logic data_valid;
    logic frame_err;
    logic busy;
    modport master(output data_out, data_valid, frame_err, busy);
    modport slave(input data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync2.sv
// uart_rx_sync2: two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk)
        if (rst) {q, m} <= 2'b11;
        else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with mid-bit sampling on the system clock
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input logic clk,
    input logic rst,
    input logic rx_in,
    uart_rx_if.master rx
);
    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int IW = clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    rx_state_t state, next;
    logic rx_s, rx_prev, shift, load, err;
    logic [CW-1:0] bit_cnt;
    logic [IW-1:0] idx;
    logic [DATA_BITS-1:0] shreg;
    uart_rx_sync2 sync (.clk(clk), .rst(rst), .d(rx_in), .q(rx_s));
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        shift = 1'b0;
        load = 1'b0;
        err = 1'b0;
        case (state)
            IDLE: next = (rx_prev && !rx_s) ? START : IDLE;
            START: next = (bit_cnt != HALF) ? START : rx_s ? IDLE : DATA;
            DATA: begin
                shift = bit_cnt == LAST;
                next = (shift && idx == IDX_LAST) ? STOP : DATA;
            end
            STOP: begin
                load = bit_cnt == LAST && rx_s;
                err = bit_cnt == LAST && !rx_s;
                next = load ? IDLE : err ? WAIT_IDLE : STOP;
            end
            WAIT_IDLE: next = rx_s ? IDLE : WAIT_IDLE;
            default: next = IDLE;
        endcase
    end
    // bit_cnt restarts on every state change and after each data-bit sample
    always_ff @(posedge clk)
        if (rst) begin
            rx_prev <= 1'b1;
            bit_cnt <= '0;
            idx <= '0;
            shreg <= '0;
            rx.data_out <= '0;
            rx.data_valid <= 1'b0;
            rx.frame_err <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            bit_cnt <= (next != state || shift) ? '0 : bit_cnt + 1'b1;
            idx <= !shift ? idx : (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (load) rx.data_out <= shreg;
            rx.data_valid <= load;
            rx.frame_err <= err;
        end
    assign rx.busy = state != IDLE;
endmodule
